// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared processor widths and opcode constants
package processor_pkg;

    localparam int ADDR_W = 18;
    localparam int WORD_W = 18;

    // Opcode space shared by the pipeline; decoded downstream of fetch.
    typedef enum logic [3:0] {
        OP_REG_ADD_IMM8,
        OP_REG_ADD,
        OP_REG_SUB,
        OP_REG_AND,
        OP_REG_OR,
        OP_REG_XOR,
        OP_LOAD,
        OP_STORE,
        OP_JUMP,
        OP_JUMP_IF_ZERO,
        OP_CALL,
        OP_RETURN,
        OP_WAIT
    } opcode_t;

endpackage

// File: rtl/processor_stage1.sv
// rtl/processor_stage1.sv - instruction-fetch stage with pc, stall and jump redirect
//
// Purpose: owns the program counter, drives a 1-cycle-latency code memory and
// presents the fetched instruction with its address to the next stage.
// Ports:
//   clock, reset          single clock, asynchronous active-high reset
//   code_addr / code_data synchronous code memory address out / word in
//   waiting_global        global stall, freezes this stage
//   jump_enable/jump_addr taken control transfer from a later stage
//   no_operation          bubble flag for the outputs below
//   ip, ip_plus_one       address of code_word and its successor
//   code_word             fetched instruction, 0 during a bubble
//   fetch_count           count of issued instructions (debug)
module processor_stage1
    import processor_pkg::*;
#(
    parameter int                    ADDR_SIZE  = ADDR_W,
    parameter int                    WORD_SIZE  = WORD_W,
    parameter logic [ADDR_SIZE-1:0]  RESET_ADDR = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [ADDR_SIZE-1:0] code_addr,
    input  logic [WORD_SIZE-1:0] code_data,
    input  logic                 waiting_global,
    input  logic                 jump_enable,
    input  logic [ADDR_SIZE-1:0] jump_addr,
    output logic                 no_operation,
    output logic [ADDR_SIZE-1:0] ip,
    output logic [ADDR_SIZE-1:0] ip_plus_one,
    output logic [WORD_SIZE-1:0] code_word,
    output logic [31:0]          fetch_count
);

    logic [ADDR_SIZE-1:0] pc;
    logic [ADDR_SIZE-1:0] ip_r;
    logic                 valid;

    // Memory address comes straight from the register; jump_addr only
    // reaches it through pc one edge later.
    assign code_addr    = pc;
    assign ip           = ip_r;
    assign ip_plus_one  = ip_r + ADDR_SIZE'(1);

    // A jump signalled this cycle squashes whatever is currently presented.
    assign no_operation = !valid || jump_enable;
    assign code_word    = no_operation ? '0 : code_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= RESET_ADDR;
            ip_r        <= '0;
            valid       <= 1'b0;
            fetch_count <= '0;
        end else if (jump_enable) begin
            // Redirect wins over stall; ip_r keeps the squashed address.
            pc    <= jump_addr;
            valid <= 1'b0;
        end else if (!waiting_global) begin
            ip_r  <= pc;
            pc    <= pc + ADDR_SIZE'(1);
            valid <= 1'b1;
            if (!no_operation) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_processor_stage1.sv
// tb/tb_processor_stage1.sv - directed self-checking bench for processor_stage1
module tb_processor_stage1;

    logic        clock = 1'b0;
    logic        reset;
    logic [17:0] code_addr;
    logic [17:0] code_data;
    logic        waiting_global;
    logic        jump_enable;
    logic [17:0] jump_addr;
    logic        no_operation;
    logic [17:0] ip;
    logic [17:0] ip_plus_one;
    logic [17:0] code_word;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;

    processor_stage1 #(
        .ADDR_SIZE (18),
        .WORD_SIZE (18),
        .RESET_ADDR(18'h0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .code_addr     (code_addr),
        .code_data     (code_data),
        .waiting_global(waiting_global),
        .jump_enable   (jump_enable),
        .jump_addr     (jump_addr),
        .no_operation  (no_operation),
        .ip            (ip),
        .ip_plus_one   (ip_plus_one),
        .code_word     (code_word),
        .fetch_count   (fetch_count)
    );

    always #5 clock = ~clock;

    // Code memory: mem[a] = a + 0x100 (18-bit), 1-cycle read, frozen by the global stall.
    always @(posedge clock) begin
        if (!waiting_global) code_data <= code_addr + 18'h100;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_out(input string tag, input logic nop, input logic [17:0] e_ip,
                           input logic [17:0] e_ipp1, input logic [17:0] e_word,
                           input logic [31:0] e_cnt);
        chk({tag, ".no_op"}, {31'd0, no_operation}, {31'd0, nop});
        chk({tag, ".ip"}, {14'd0, ip}, {14'd0, e_ip});
        chk({tag, ".ip_plus_one"}, {14'd0, ip_plus_one}, {14'd0, e_ipp1});
        chk({tag, ".code_word"}, {14'd0, code_word}, {14'd0, e_word});
        chk({tag, ".fetch_count"}, fetch_count, e_cnt);
    endtask

    initial begin
        reset = 1'b1;
        waiting_global = 1'b0;
        jump_enable = 1'b0;
        jump_addr = '0;
        tick();
        chk_out("reset", 1'b1, 18'h0, 18'h1, 18'h0, 32'd0);
        chk("reset.code_addr", {14'd0, code_addr}, 32'h0);

        // Release: first cycle is a bubble, then sequential fetch.
        reset = 1'b0;
        #1;
        chk_out("rel.c1", 1'b1, 18'h0, 18'h1, 18'h0, 32'd0);
        tick();
        chk_out("run.ip0", 1'b0, 18'h0, 18'h1, 18'h100, 32'd0);
        tick();
        chk_out("run.ip1", 1'b0, 18'h1, 18'h2, 18'h101, 32'd1);
        tick();
        chk_out("run.ip2", 1'b0, 18'h2, 18'h3, 18'h102, 32'd2);
        tick();
        chk_out("run.ip3", 1'b0, 18'h3, 18'h4, 18'h103, 32'd3);
        tick();
        tick();
        chk_out("run.ip5", 1'b0, 18'h5, 18'h6, 18'h105, 32'd5);

        // Jump to 0x20 while ip=5: squashed immediately, one bubble, then target.
        jump_enable = 1'b1;
        jump_addr = 18'h20;
        #1;
        chk("jmp.same.no_op", {31'd0, no_operation}, 32'd1);
        chk("jmp.same.code_word", {14'd0, code_word}, 32'd0);
        tick();
        jump_enable = 1'b0;
        #1;
        chk("jmp.bub.no_op", {31'd0, no_operation}, 32'd1);
        chk("jmp.bub.code_addr", {14'd0, code_addr}, 32'h20);
        tick();
        chk_out("jmp.tgt", 1'b0, 18'h20, 18'h21, 18'h120, 32'd5);

        // Move to ip=3, then stall 5 cycles.
        jump_enable = 1'b1;
        jump_addr = 18'h3;
        tick();
        jump_enable = 1'b0;
        tick();
        chk_out("pre.stall", 1'b0, 18'h3, 18'h4, 18'h103, 32'd5);
        waiting_global = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("stall", 1'b0, 18'h3, 18'h4, 18'h103, 32'd5);
            chk("stall.code_addr", {14'd0, code_addr}, 32'h4);
        end
        waiting_global = 1'b0;
        tick();
        chk_out("stall.resume", 1'b0, 18'h4, 18'h5, 18'h104, 32'd6);

        // Jump and stall together: jump taken, bubble held until both drop.
        jump_enable = 1'b1;
        waiting_global = 1'b1;
        jump_addr = 18'h40;
        #1;
        chk("jw.same.no_op", {31'd0, no_operation}, 32'd1);
        tick();
        jump_enable = 1'b0;
        #1;
        chk("jw.code_addr", {14'd0, code_addr}, 32'h40);
        chk("jw.bub.no_op", {31'd0, no_operation}, 32'd1);
        tick();
        chk("jw.hold.no_op", {31'd0, no_operation}, 32'd1);
        chk("jw.hold.code_addr", {14'd0, code_addr}, 32'h40);
        waiting_global = 1'b0;
        tick();
        chk_out("jw.tgt", 1'b0, 18'h40, 18'h41, 18'h140, 32'd6);

        // Address wrap at 0x3FFFF.
        jump_enable = 1'b1;
        jump_addr = 18'h3FFFF;
        tick();
        jump_enable = 1'b0;
        tick();
        chk_out("wrap.top", 1'b0, 18'h3FFFF, 18'h0, 18'h000FF, 32'd6);
        tick();
        chk_out("wrap.zero", 1'b0, 18'h0, 18'h1, 18'h100, 32'd7);

        // Reach ip=7, stall, then assert reset mid-cycle.
        jump_enable = 1'b1;
        jump_addr = 18'h7;
        tick();
        jump_enable = 1'b0;
        tick();
        chk_out("pre.rst", 1'b0, 18'h7, 18'h8, 18'h107, 32'd7);
        waiting_global = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk_out("async.rst", 1'b1, 18'h0, 18'h1, 18'h0, 32'd0);
        chk("async.rst.code_addr", {14'd0, code_addr}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        waiting_global = 1'b0;
        tick();
        chk_out("rst.restart", 1'b0, 18'h0, 18'h1, 18'h100, 32'd0);
        tick();
        chk_out("rst.next", 1'b0, 18'h1, 18'h2, 18'h101, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
